// File: rtl/vx_fpu_fflags_arb_pkg.sv
// Shared types for the FPU fflags arbiter and its round-robin helper.
// fflags_t holds one RISC-V exception flag set, MSB first: {NV,DZ,OF,UF,NX}.
package vx_fpu_fflags_arb_pkg;

  localparam int FFLAGS_BITS = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Width of a warp / slot index; never narrower than one bit.
  function automatic int nw_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_fpu_fflags_arb_rr_find_first.sv
// Round-robin first-set finder: rotates the request vector so start_i sits at
// bit 0, priority-encodes the lowest set bit, then rotates the index back.
// Shared by the round-robin arbiters in this codebase.
module vx_rr_find_first
  import vx_fpu_fflags_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = nw_bits(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         valid_o,
  output logic [W-1:0] index_o
);

  localparam logic [W:0] N_W = (W + 1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] pos;
  logic [W:0]   sum;

  // Rotate, pick lowest set bit, map back to an absolute index modulo N.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    rot = N'({req_i, req_i} >> start_i);
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = W'(i);
    end
    sum = {1'b0, start_i} + {1'b0, pos};
    if (sum >= N_W) sum = sum - N_W;
    index_o = sum[W-1:0];
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/vx_fpu_fflags_arb.sv
// FPU fflags write-port arbiter.
// FPU requesters write exception flags fire-and-forget; flags are OR-merged
// into a per-warp accumulator and drained to the single CSR fflags write port
// one warp per cycle, round-robin across warps. A per-warp pending query lets
// the CSR unit stall an fflags read until that warp's flags are committed.
// Optional build macro: VX_FPU_FFLAGS_ARB_BYPASS_EN -- when nothing is pending
// and this cycle's flags target a single warp, forward them to the CSR port in
// the same cycle instead of going through the accumulator.
module vx_fpu_fflags_arb
  import vx_fpu_fflags_arb_pkg::*;
#(
  parameter  int NUM_WARPS = 4,
  parameter  int NUM_REQS  = 2,
  localparam int NW_BITS   = nw_bits(NUM_WARPS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_write_enable,
  input  logic [NUM_REQS*NW_BITS-1:0]     req_write_wid,
  input  logic [NUM_REQS*FFLAGS_BITS-1:0] req_write_fflags,
  output logic                            csr_write_enable,
  output logic [NW_BITS-1:0]              csr_write_wid,
  output logic [FFLAGS_BITS-1:0]          csr_write_fflags,
  input  logic [NW_BITS-1:0]              query_wid,
  output logic                            query_pending,
  output logic                            pending_any
);

  logic [NUM_WARPS-1:0]   pend_q, pend_d;
  fflags_t [NUM_WARPS-1:0] acc_q, acc_d;
  logic [NW_BITS-1:0]     rr_ptr_q, rr_ptr_d;

  fflags_t [NUM_WARPS-1:0] merged;
  logic [NUM_WARPS-1:0]   hit;

  logic                   rr_valid;
  logic [NW_BITS-1:0]     rr_idx;

  logic                   byp_fire;
  logic [NW_BITS-1:0]     byp_wid;

  logic                   sel_en;
  logic [NW_BITS-1:0]     sel_wid;
  fflags_t                sel_fl;
  logic [NUM_WARPS-1:0]   drain;

  // Merge this cycle's requests per warp; all-zero flag writes carry no
  // information and are dropped so they never raise pending.
  always_comb begin
    merged = '0;
    hit    = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (req_write_enable[r]
            && (req_write_fflags[r*FFLAGS_BITS +: FFLAGS_BITS] != '0)
            && (req_write_wid[r*NW_BITS +: NW_BITS] == NW_BITS'(w))) begin
          merged[w] = merged[w] | req_write_fflags[r*FFLAGS_BITS +: FFLAGS_BITS];
          hit[w]    = 1'b1;
        end
      end
    end
  end

  // Round-robin pick among pending warps, starting at rr_ptr.
  vx_rr_find_first #(
    .N (NUM_WARPS)
  ) u_rr_find_first (
    .req_i   (pend_q),
    .start_i (rr_ptr_q),
    .valid_o (rr_valid),
    .index_o (rr_idx)
  );

`ifdef VX_FPU_FFLAGS_ARB_BYPASS_EN
  // Encode the single targeted warp for same-cycle forwarding.
  always_comb begin
    byp_wid = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (hit[w]) byp_wid = NW_BITS'(w);
    end
  end

  assign byp_fire = (pend_q == '0) && $onehot(hit);
`else
  assign byp_wid  = '0;
  assign byp_fire = 1'b0;
`endif

  // Choose what goes to the CSR port this cycle: forwarded flags, or the
  // accumulator of the round-robin winner.
  always_comb begin
    sel_en  = 1'b0;
    sel_wid = '0;
    sel_fl  = '0;
    drain   = '0;
    if (byp_fire) begin
      sel_en  = 1'b1;
      sel_wid = byp_wid;
      sel_fl  = merged[byp_wid];
    end else if (rr_valid) begin
      sel_en        = 1'b1;
      sel_wid       = rr_idx;
      sel_fl        = acc_q[rr_idx];
      drain[rr_idx] = 1'b1;
    end
  end

  // Next state: a drained warp sends its old flags; flags arriving in the same
  // cycle start a fresh accumulation, so nothing is ever lost.
  always_comb begin
    pend_d   = pend_q;
    acc_d    = acc_q;
    rr_ptr_d = rr_ptr_q;
    if (!byp_fire) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pend_d[w] = (pend_q[w] & ~drain[w]) | hit[w];
        acc_d[w]  = drain[w] ? merged[w] : (acc_q[w] | merged[w]);
      end
    end
    if (sel_en) begin
      rr_ptr_d = (sel_wid == NW_BITS'(NUM_WARPS - 1)) ? '0 : sel_wid + 1'b1;
    end
  end

  // State registers; reset discards everything still pending.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the accumulator array is reset along with pend: a stale acc would
    // otherwise be ORed into the first post-reset flags of that warp.
    if (reset) begin
      pend_q   <= '0;
      acc_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pend_q   <= pend_d;
      acc_q    <= acc_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign csr_write_enable = sel_en;
  assign csr_write_wid    = sel_wid;
  assign csr_write_fflags = sel_fl;
  assign query_pending    = pend_q[query_wid] | hit[query_wid];
  assign pending_any      = (|pend_q) | (|hit);

endmodule

// File: tb/tb_vx_fpu_fflags_arb.sv
// Self-checking bench for vx_fpu_fflags_arb (NUM_WARPS=4, NUM_REQS=2).
// Directed steps with constant expectations, then random traffic compared
// every cycle against a per-warp accumulate-and-scan reference model.
// Define VX_FPU_FFLAGS_ARB_BYPASS_EN to exercise the same-cycle forward path.
module tb_vx_fpu_fflags_arb;

  localparam int NW = 4;
  localparam int NR = 2;
  localparam int WB = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_en;
  logic [NR*WB-1:0] req_wid;
  logic [NR*5-1:0] req_fl;
  logic            csr_en;
  logic [WB-1:0]   csr_wid;
  logic [4:0]      csr_fl;
  logic [WB-1:0]   query_wid;
  logic            query_pending;
  logic            pending_any;

  vx_fpu_fflags_arb #(
    .NUM_WARPS (NW),
    .NUM_REQS  (NR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_write_enable (req_en),
    .req_write_wid    (req_wid),
    .req_write_fflags (req_fl),
    .csr_write_enable (csr_en),
    .csr_write_wid    (csr_wid),
    .csr_write_fflags (csr_fl),
    .query_wid        (query_wid),
    .query_pending    (query_pending),
    .pending_any      (pending_any)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: which warps owe the CSR unit flags, what they owe, and
  // where the round-robin search starts.
  bit m_pend[NW];
  int m_acc[NW];
  int m_ptr;
  bit n_pend[NW];
  int n_acc[NW];
  int n_ptr;
  int e_en, e_wid, e_fl, e_qp, e_any;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) begin
      m_pend[w] = 1'b0;
      m_acc[w]  = 0;
    end
    m_ptr = 0;
  endtask

  // Expected outputs and next state from the model state and current inputs.
  task automatic model_eval();
    int  merged[NW];
    bit  hit[NW];
    int  nhit;
    int  hw;
    bit  anyp;
    bit  byp;
    nhit = 0; hw = 0; anyp = 1'b0; byp = 1'b0;
    for (int w = 0; w < NW; w++) begin
      merged[w] = 0;
      hit[w]    = 1'b0;
    end
    for (int r = 0; r < NR; r++) begin
      if (req_en[r] && req_fl[r*5 +: 5] != 5'd0) begin
        merged[req_wid[r*WB +: WB]] |= int'(req_fl[r*5 +: 5]);
        hit[req_wid[r*WB +: WB]] = 1'b1;
      end
    end
    for (int w = 0; w < NW; w++) begin
      if (hit[w]) begin nhit++; hw = w; end
      anyp |= m_pend[w];
    end
    n_pend = m_pend;
    n_acc  = m_acc;
    n_ptr  = m_ptr;
    e_en = 0; e_wid = 0; e_fl = 0;
`ifdef VX_FPU_FFLAGS_ARB_BYPASS_EN
    byp = !anyp && (nhit == 1);
`endif
    if (byp) begin
      e_en = 1; e_wid = hw; e_fl = merged[hw];
      n_ptr = (hw + 1) % NW;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (e_en == 0 && m_pend[(m_ptr + k) % NW]) begin
          e_en = 1; e_wid = (m_ptr + k) % NW; e_fl = m_acc[e_wid];
        end
      end
      if (e_en == 1) begin
        n_pend[e_wid] = 1'b0;
        n_acc[e_wid]  = 0;
        n_ptr = (e_wid + 1) % NW;
      end
      for (int w = 0; w < NW; w++) begin
        if (hit[w]) begin
          n_pend[w] = 1'b1;
          n_acc[w] |= merged[w];
        end
      end
    end
    e_qp  = (m_pend[query_wid] || hit[query_wid]) ? 1 : 0;
    e_any = (anyp || nhit > 0) ? 1 : 0;
  endtask

  // Sample at the falling edge and compare all outputs against the model.
  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    check({tag, "_en"},  32'(csr_en),        e_en);
    check({tag, "_wid"}, 32'(csr_wid),       e_wid);
    check({tag, "_fl"},  32'(csr_fl),        e_fl);
    check({tag, "_qp"},  32'(query_pending), e_qp);
    check({tag, "_any"}, 32'(pending_any),   e_any);
  endtask

  task automatic advance();
    @(posedge clk);
    m_pend = n_pend;
    m_acc  = n_acc;
    m_ptr  = n_ptr;
    #1;
  endtask

  // Model-checked cycle plus constant expectations taken straight from the
  // behaviour description.
  task automatic step_chk(input string tag, input int xen, input int xwid,
                          input int xfl, input int xqp);
    sample(tag);
    check({tag, "_c_en"},  32'(csr_en),        xen);
    check({tag, "_c_wid"}, 32'(csr_wid),       xwid);
    check({tag, "_c_fl"},  32'(csr_fl),        xfl);
    check({tag, "_c_qp"},  32'(query_pending), xqp);
    advance();
  endtask

  task automatic idle_inputs();
    req_en  = '0;
    req_wid = '0;
    req_fl  = '0;
  endtask

  task automatic drive(input int r, input int wid, input int fl);
    req_en[r]          = 1'b1;
    req_wid[r*WB +: WB] = WB'(wid);
    req_fl[r*5 +: 5]   = 5'(fl);
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    query_wid = '0;
    idle_inputs();
    model_clear();

    // Reset held three cycles: everything quiet.
    repeat (3) @(posedge clk);
    #1;
    check("rst_en",  32'(csr_en),        0);
    check("rst_wid", 32'(csr_wid),       0);
    check("rst_fl",  32'(csr_fl),        0);
    check("rst_qp",  32'(query_pending), 0);
    check("rst_any", 32'(pending_any),   0);
    reset = 1'b0;
    step_chk("idle", 0, 0, 0, 0);

`ifdef VX_FPU_FFLAGS_ARB_BYPASS_EN
    // Idle, single write to warp 3: forwarded in the same cycle, nothing kept.
    query_wid = 2'd3;
    drive(0, 3, 5'b01000);
    step_chk("byp_t0", 1, 3, 5'b01000, 1);
    idle_inputs();
    step_chk("byp_t1", 0, 0, 0, 0);
    // Two warps targeted at once: no forward, normal accumulate path.
    drive(0, 1, 5'b00001);
    drive(1, 2, 5'b00010);
    query_wid = 2'd1;
    step_chk("byp_two", 0, 0, 0, 1);
    idle_inputs();
    step_chk("byp_two1", 1, 1, 5'b00001, 1);
    step_chk("byp_two2", 1, 2, 5'b00010, 0);
`else
    // Single write: one cycle to the CSR port, pending visible immediately.
    query_wid = 2'd2;
    drive(0, 2, 5'b00001);
    step_chk("lat_t0", 0, 0, 0, 1);
    idle_inputs();
    step_chk("lat_t1", 1, 2, 5'b00001, 1);
    step_chk("lat_t2", 0, 0, 0, 0);

    // Two requesters, same warp: one merged drain.
    query_wid = 2'd1;
    drive(0, 1, 5'b10000);
    drive(1, 1, 5'b00100);
    step_chk("merge_t0", 0, 0, 0, 1);
    idle_inputs();
    step_chk("merge_t1", 1, 1, 5'b10100, 1);
    step_chk("merge_t2", 0, 0, 0, 0);

    // Round-robin order from rr_ptr=0: warps 0 and 3, then 1 -> 0,1,3.
    hard_reset();
    query_wid = 2'd3;
    drive(0, 0, 5'b00001);
    drive(1, 3, 5'b00010);
    step_chk("rr_t0", 0, 0, 0, 1);
    idle_inputs();
    drive(0, 1, 5'b00100);
    step_chk("rr_t1", 1, 0, 5'b00001, 1);
    idle_inputs();
    step_chk("rr_t2", 1, 1, 5'b00100, 1);
    step_chk("rr_t3", 1, 3, 5'b00010, 1);
    step_chk("rr_t4", 0, 0, 0, 0);
    // Pointer wrapped to 0: warp 0 again beats warp 3.
    drive(0, 3, 5'b01000);
    drive(1, 0, 5'b10000);
    step_chk("rr_t5", 0, 0, 0, 1);
    idle_inputs();
    step_chk("rr_t6", 1, 0, 5'b10000, 1);
    step_chk("rr_t7", 1, 3, 5'b01000, 1);

    // Drain/write collision on warp 1: old flags go now, new flags next.
    query_wid = 2'd1;
    drive(0, 1, 5'b00010);
    step_chk("col_tm1", 0, 0, 0, 1);
    idle_inputs();
    drive(0, 1, 5'b00001);
    step_chk("col_t0", 1, 1, 5'b00010, 1);
    idle_inputs();
    step_chk("col_t1", 1, 1, 5'b00001, 1);
    step_chk("col_t2", 0, 0, 0, 0);
`endif

    // Zero-flag write is ignored.
    query_wid = 2'd2;
    drive(0, 2, 5'b00000);
    drive(1, 2, 5'b00000);
    step_chk("zero_t0", 0, 0, 0, 0);
    idle_inputs();
    step_chk("zero_t1", 0, 0, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NR; r++) begin
        req_en[r]           = 1'($urandom_range(0, 1));
        req_wid[r*WB +: WB] = WB'($urandom_range(0, NW - 1));
        req_fl[r*5 +: 5]    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      end
      query_wid = WB'($urandom_range(0, NW - 1));
      sample("rnd");
      advance();
    end
    idle_inputs();

    // Reset mid-operation with warps 0 and 2 pending: outputs clear at once.
    hard_reset();
    query_wid = 2'd2;
    drive(0, 0, 5'b00001);
    drive(1, 2, 5'b00100);
    sample("pre_rst");
    advance();
    idle_inputs();
    #1;
    reset = 1'b1;
    #1;
    check("arst_en",  32'(csr_en),        0);
    check("arst_wid", 32'(csr_wid),       0);
    check("arst_fl",  32'(csr_fl),        0);
    check("arst_qp",  32'(query_pending), 0);
    check("arst_any", 32'(pending_any),   0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_chk("post_rst", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
